// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared modes, states and channel helpers for the 3x3 RGB convolver
package conv_pkg;

   localparam logic [1:0] MODE_BYPASS = 2'd0;
   localparam logic [1:0] MODE_GAUSS  = 2'd1;
   localparam logic [1:0] MODE_SHARP  = 2'd2;

   localparam int MAX_CB = 12;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DRAIN} state_t;

   function automatic logic [MAX_CB-1:0] get_chan(input logic [3*MAX_CB-1:0] pix,
                                                  input int lsb, input int bits);
      return MAX_CB'((pix >> lsb) & ~({(3*MAX_CB){1'b1}} << bits));
   endfunction

   function automatic logic [3*MAX_CB-1:0] pack_pix(input logic [MAX_CB-1:0] r,
                                                    input logic [MAX_CB-1:0] g,
                                                    input logic [MAX_CB-1:0] b,
                                                    input int g_bits, input int b_bits);
      return ({{(2*MAX_CB){1'b0}}, r} << (g_bits + b_bits))
           | ({{(2*MAX_CB){1'b0}}, g} << b_bits)
           |  {{(2*MAX_CB){1'b0}}, b};
   endfunction

   function automatic logic [MAX_CB-1:0] clamp_chan(input logic signed [MAX_CB+3:0] v,
                                                    input int bits);
      logic [MAX_CB-1:0] hi;
      hi = ~({MAX_CB{1'b1}} << bits);
      if (v < 0)
         return '0;
      if (v > $signed({4'b0000, hi}))
         return hi;
      return v[MAX_CB-1:0];
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - two-row circular line store, one write and two reads per beat
module conv_line_buffer #(
   parameter int IMG_W = 320,
   parameter int PIX_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [PIX_W-1:0] wdata,
   output logic [PIX_W-1:0] tap1,
   output logic [PIX_W-1:0] tap2
);
   localparam int AW = $clog2(IMG_W);

   // Each entry holds {pixel two lines back, pixel one line back} for its column.
   logic [2*PIX_W-1:0] mem [IMG_W];
   logic [AW-1:0]      col;
   logic [2*PIX_W-1:0] rd;

   assign rd   = mem[col];
   assign tap1 = rd[PIX_W-1:0];
   assign tap2 = rd[2*PIX_W-1:PIX_W];

   always_ff @(posedge clk) begin
      if (rst)
         col <= '0;
      else if (we)
         col <= (col == AW'(IMG_W-1)) ? '0 : col + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (we)
         mem[col] <= {tap1, wdata};
   end

endmodule

// File: rtl/conv3x3_rgb_stream.sv
// rtl/conv3x3_rgb_stream.sv - streaming 3x3 RGB convolver with bypass/gaussian/sharpen modes
module conv3x3_rgb_stream
   import conv_pkg::*;
#(
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int R_BITS = 5,
   parameter int G_BITS = 6,
   parameter int B_BITS = 5,
   parameter int PIX_W  = R_BITS + G_BITS + B_BITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_data,
   output logic             out_sof,
   output logic             out_eol,
   output logic             busy,
   output logic             done
);
   localparam int NPIX = IMG_W * IMG_H;
   localparam int XW   = $clog2(IMG_W);
   localparam int YW   = $clog2(IMG_H);
   localparam int BW   = $clog2(NPIX + IMG_W + 1);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W-1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H-1);

   state_t          state;
   logic [1:0]      mode_q;
   logic [BW-1:0]   bcnt;
   logic [XW-1:0]   cx;
   logic [YW-1:0]   cy;
   logic            win_pend;
   logic            out_last;
   logic [PIX_W-1:0] win [3][3];
   logic [PIX_W-1:0] tap1, tap2, pix_in, filt, centre;
   logic            adv, beat, border;

   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv && (state == ST_RUN);
   assign beat     = (in_valid && in_ready) || (adv && state == ST_FLUSH);
   assign pix_in   = (state == ST_RUN) ? in_data : '0;
   assign centre   = win[1][1];
   assign border   = (cx == '0) || (cx == X_LAST) || (cy == '0) || (cy == Y_LAST);

   conv_line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lbuf (
      .clk   (clk),
      .rst   (rst),
      .we    (beat),
      .wdata (pix_in),
      .tap1  (tap1),
      .tap2  (tap2)
   );

   // Column 2 is the newest; row 2 is the current input line.
   always_ff @(posedge clk) begin
      if (beat) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= tap2;
         win[1][2] <= tap1;
         win[2][2] <= pix_in;
      end
   end

   for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      localparam int CB = (ch == 0) ? B_BITS : (ch == 1) ? G_BITS : R_BITS;
      localparam int CL = (ch == 0) ? 0 : (ch == 1) ? B_BITS : B_BITS + G_BITS;
      logic [CB+3:0]        e [3][3];
      logic [CB+3:0]        gsum;
      logic signed [CB+3:0] ssum;
      logic [CB-1:0]        res;

      always_comb begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               e[r][c] = (CB+4)'(get_chan((3*MAX_CB)'(win[r][c]), CL, CB));
         gsum = e[0][0] + (e[0][1] << 1) + e[0][2]
              + (e[1][0] << 1) + (e[1][1] << 2) + (e[1][2] << 1)
              + e[2][0] + (e[2][1] << 1) + e[2][2] + (CB+4)'(8);
         // Exact result fits CB+4 signed bits, so modular arithmetic reinterpreted as signed is safe.
         ssum = $signed((e[1][1] << 2) + e[1][1] - e[0][1] - e[2][1] - e[1][0] - e[1][2]);
         case (mode_q)
            MODE_GAUSS: res = CB'(gsum >> 4);
            MODE_SHARP: res = CB'(clamp_chan((MAX_CB+4)'(ssum), CB));
            default:    res = e[1][1][CB-1:0];
         endcase
      end
   end

   assign filt = border ? centre
               : PIX_W'(pack_pix(MAX_CB'(g_ch[2].res), MAX_CB'(g_ch[1].res),
                                 MAX_CB'(g_ch[0].res), G_BITS, B_BITS));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         mode_q    <= MODE_BYPASS;
         bcnt      <= '0;
         cx        <= '0;
         cy        <= '0;
         win_pend  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (adv) begin
            out_valid <= win_pend;
            if (win_pend) begin
               out_data <= filt;
               out_sof  <= (cx == '0) && (cy == '0);
               out_eol  <= (cx == X_LAST);
               out_last <= (cx == X_LAST) && (cy == Y_LAST);
               if (cx == X_LAST) begin
                  cx <= '0;
                  cy <= cy + 1'b1;
               end else begin
                  cx <= cx + 1'b1;
               end
            end
         end
         // A beat past the first IMG_W+1 places a fresh centre pixel in the window.
         if (beat)
            win_pend <= (bcnt >= BW'(IMG_W+1));
         else if (adv)
            win_pend <= 1'b0;
         case (state)
            ST_IDLE: if (start) begin
               state  <= ST_RUN;
               mode_q <= mode;
               busy   <= 1'b1;
               bcnt   <= '0;
               cx     <= '0;
               cy     <= '0;
            end
            ST_RUN: if (beat) begin
               bcnt <= bcnt + 1'b1;
               if (bcnt == BW'(NPIX-1))
                  state <= ST_FLUSH;
            end
            ST_FLUSH: if (beat) begin
               bcnt <= bcnt + 1'b1;
               if (bcnt == BW'(NPIX+IMG_W))
                  state <= ST_DRAIN;
            end
            ST_DRAIN: if (out_valid && out_ready && out_last) begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv3x3_rgb_stream.sv
// tb/tb_conv3x3_rgb_stream.sv - scoreboard bench for conv3x3_rgb_stream on a 5x5 RGB565 frame
module tb_conv3x3_rgb_stream;
   localparam int W  = 5;
   localparam int H  = 5;
   localparam int NP = W * H;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = 16'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        out_sof, out_eol, busy, done;

   typedef struct packed {
      logic [15:0] d;
      logic        sof;
      logic        eol;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [15:0] img [NP];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          rdy_mode = 0;
   int          gap_max = 0;
   bit          done_exp = 1'b0;
   bit          prev_stall = 1'b0;
   logic [15:0] prev_data = 16'd0;

   always #5 clk = ~clk;

   conv3x3_rgb_stream #(.IMG_W(W), .IMG_H(H), .R_BITS(5), .G_BITS(6), .B_BITS(5)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sof   (out_sof),
      .out_eol   (out_eol),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int chan(input int x, input int y, input int lsb, input int bits);
      return (int'(img[y*W+x]) >> lsb) & ((1 << bits) - 1);
   endfunction

   task automatic push_expected(input int m);
      int lsb, bits, v, wgt;
      logic [15:0] e;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            e = img[y*W+x];
            if (x > 0 && x < W-1 && y > 0 && y < H-1 && (m == 1 || m == 2)) begin
               e = 16'd0;
               for (int ch = 0; ch < 3; ch++) begin
                  lsb  = (ch == 0) ? 0 : (ch == 1) ? 5 : 11;
                  bits = (ch == 1) ? 6 : 5;
                  if (m == 1) begin
                     v = 0;
                     for (int dy = -1; dy <= 1; dy++)
                        for (int dx = -1; dx <= 1; dx++) begin
                           wgt = (dx == 0 ? 2 : 1) * (dy == 0 ? 2 : 1);
                           v += wgt * chan(x+dx, y+dy, lsb, bits);
                        end
                     v = (v + 8) / 16;
                  end else begin
                     v = 5 * chan(x, y, lsb, bits) - chan(x, y-1, lsb, bits) - chan(x, y+1, lsb, bits)
                       - chan(x-1, y, lsb, bits) - chan(x+1, y, lsb, bits);
                     if (v < 0) v = 0;
                     if (v > (1 << bits) - 1) v = (1 << bits) - 1;
                  end
                  e = e | 16'(v << lsb);
               end
            end
            exp_q.push_back(exp_t'{e, (x == 0 && y == 0), (x == W-1)});
         end
      end
   endtask

   task automatic send_pix(input logic [15:0] p, input int gap);
      int n;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = p;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("in_accept_timeout", 32'(n >= 200), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && n < 2000) begin
         n++;
         @(negedge clk);
      end
      check("frame_timeout", 32'(n >= 2000), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int m);
      push_expected(m);
      start = 1'b1;
      mode  = 2'(m);
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < NP; k++)
         send_pix(img[k], gap_max > 0 ? int'($urandom_range(0, gap_max)) : 0);
      wait_idle();
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         done_exp   = 1'b0;
      end else begin
         if (done || done_exp)
            check("done_pulse", 32'(done), 32'(done_exp));
         done_exp = 1'b0;
         if (prev_stall)
            check("stall_hold", {15'd0, out_valid, out_data}, {15'd0, 1'b1, prev_data});
         if (out_valid && !out_ready)
            check("in_ready_stall", 32'(in_ready), 32'd0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_output", 32'(exp_q.size()), 32'd1);
            end else begin
               mon_e = exp_q.pop_front();
               check("pixel", 32'({out_data, out_sof, out_eol}), 32'(mon_e));
               if (exp_q.size() == 0)
                  done_exp = 1'b1;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_done",      32'(done),      32'd0);
      check("rst_out_sof",   32'(out_sof),   32'd0);
      check("rst_out_eol",   32'(out_eol),   32'd0);
      @(posedge clk);
      #1;

      for (int k = 0; k < NP; k++) img[k] = 16'(k);
      run_frame(0);
      for (int k = 0; k < NP; k++) img[k] = 16'hFFFF;
      run_frame(1);
      for (int k = 0; k < NP; k++) img[k] = 16'd0;
      img[2*W+2] = 16'(16 << 11);
      run_frame(1);
      for (int k = 0; k < NP; k++) img[k] = 16'd0;
      img[2*W+2] = 16'(63 << 5);
      run_frame(2);

      rdy_mode = 1;
      gap_max  = 3;
      for (int k = 0; k < NP; k++) img[k] = 16'(k);
      run_frame(0);
      for (int k = 0; k < NP; k++) img[k] = 16'd0;
      img[2*W+2] = 16'(16 << 11);
      run_frame(1);

      rdy_mode = 2;
      for (int m = 0; m < 4; m++) begin
         repeat (2) begin
            for (int k = 0; k < NP; k++) img[k] = 16'($urandom);
            run_frame(m);
         end
      end

      rdy_mode = 0;
      gap_max  = 0;
      for (int k = 0; k < NP; k++) img[k] = 16'(k);
      push_expected(0);
      start = 1'b1;
      mode  = 2'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < 7; k++) send_pix(img[k], 0);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_busy",      32'(busy),      32'd0);
      check("midrst_in_ready",  32'(in_ready),  32'd0);
      check("midrst_done",      32'(done),      32'd0);
      @(posedge clk);
      #1;
      run_frame(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
